// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the uart_fifo_core TX/RX engines
// and their FIFOs.
package uart_pkg;

  // Frame position, shared by the TX and RX state machines.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Line level while no frame is in flight (also the stop-bit level).
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Width of a counter that must hold the values 0 .. n-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with first-word fall-through output.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
// pop_data reads as zero while the FIFO is empty.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // The extra MSB on each pointer tells a full FIFO apart from an empty one.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Advance the pointers on accepted pushes and pops.
  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Write the storage array.
  // NOTE: the array has no reset; the empty flag masks stale entries, so it maps to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART with a FIFO in each direction.
// Frame: start(0), DATA_BITS data LSB first, optional even parity, stop(1).
// Optional feature: define UART_PARITY_EN to send and check the parity bit.
// When it is defined, the rx_parity_err port also exists.
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  output logic                 rx_frame_err
`ifdef UART_PARITY_EN
  ,
  output logic                 rx_parity_err
`endif
);

  localparam int BAUD_W = cnt_width(CLKS_PER_BIT);
  localparam int BIT_W  = cnt_width(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  // ---------------------------------------------------------------- TX side
  uart_state_t          tx_state, tx_state_n;
  logic [BAUD_W-1:0]    tx_baud, tx_baud_n;
  logic [BIT_W-1:0]     tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_word, tx_word_n;
  logic                 tx_line_n;
  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && tx_ready;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_push),
    .push_data (tx_data),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  // TX next state: sequence the frame and pick the line level for the next cycle.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    tx_state_n = tx_state;
    tx_baud_n  = tx_baud + 1'b1;
    tx_bit_n   = tx_bit;
    tx_word_n  = tx_word;
    tx_pop     = 1'b0;
    tx_line_n  = UART_IDLE_LEVEL;
    case (tx_state)
      IDLE: begin
        tx_baud_n = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_word_n  = tx_head;
          tx_state_n = START;
        end
      end
      START: begin
        if (tx_baud == BAUD_LAST) begin
          tx_baud_n  = '0;
          tx_bit_n   = '0;
          tx_state_n = DATA;
        end
      end
      DATA: begin
        if (tx_baud == BAUD_LAST) begin
          tx_baud_n = '0;
          if (tx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
            tx_state_n = PARITY;
`else
            tx_state_n = STOP;
`endif
          end else begin
            tx_bit_n = tx_bit + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tx_baud == BAUD_LAST) begin
          tx_baud_n  = '0;
          tx_state_n = STOP;
        end
      end
      STOP: begin
        if (tx_baud == BAUD_LAST) begin
          tx_baud_n = '0;
          // Chain straight into the next frame when more data is queued.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_word_n  = tx_head;
            tx_state_n = START;
          end else begin
            tx_state_n = IDLE;
          end
        end
      end
      default: begin
        tx_baud_n  = '0;
        tx_state_n = IDLE;
      end
    endcase
    case (tx_state_n)
      START:   tx_line_n = ~UART_IDLE_LEVEL;
      DATA:    tx_line_n = tx_word_n[tx_bit_n];
      PARITY:  tx_line_n = ^tx_word_n;
      default: tx_line_n = UART_IDLE_LEVEL;
    endcase
  end

  // TX registers; tx is driven straight from a flop so the pin never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= IDLE;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_word  <= '0;
      tx       <= UART_IDLE_LEVEL;
    end else begin
      tx_state <= tx_state_n;
      tx_baud  <= tx_baud_n;
      tx_bit   <= tx_bit_n;
      tx_word  <= tx_word_n;
      tx       <= tx_line_n;
    end
  end

  // ---------------------------------------------------------------- RX side
  logic                 rx_meta, rx_sync, rx_prev, rx_fall;
  uart_state_t          rx_state, rx_state_n;
  logic [BAUD_W-1:0]    rx_baud, rx_baud_n;
  logic [BIT_W-1:0]     rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic                 frame_err_n, overrun_n;
`ifdef UART_PARITY_EN
  logic                 rx_par_bit, rx_par_bit_n;
  logic                 parity_err_n;
`endif

  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;
  // A high-to-low step on the synchronised line. It also re-arms only after the line reads high.
  assign rx_fall  = (rx_prev == UART_IDLE_LEVEL) && (rx_sync != UART_IDLE_LEVEL);

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (rx_pop),
    .pop_data  (rx_data),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // Two-flop synchroniser for the asynchronous pin, plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= UART_IDLE_LEVEL;
      rx_sync <= UART_IDLE_LEVEL;
      rx_prev <= UART_IDLE_LEVEL;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX next state: sample at bit centres and judge the frame at the stop bit.
  always_comb begin
    rx_state_n  = rx_state;
    rx_baud_n   = rx_baud + 1'b1;
    rx_bit_n    = rx_bit;
    rx_shift_n  = rx_shift;
    rx_push     = 1'b0;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_bit_n = rx_par_bit;
    parity_err_n = 1'b0;
`endif
    case (rx_state)
      IDLE: begin
        rx_baud_n = '0;
        if (rx_fall) rx_state_n = START;
      end
      START: begin
        // Half a bit in: a line that is high again means the low was only a glitch.
        if (rx_baud == BAUD_HALF) begin
          rx_baud_n  = '0;
          rx_bit_n   = '0;
          rx_state_n = (rx_sync == UART_IDLE_LEVEL) ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rx_baud == BAUD_LAST) begin
          rx_baud_n  = '0;
          rx_shift_n = {rx_sync, rx_shift[DATA_BITS-1:1]};
          if (rx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
            rx_state_n = PARITY;
`else
            rx_state_n = STOP;
`endif
          end else begin
            rx_bit_n = rx_bit + 1'b1;
          end
        end
      end
      PARITY: begin
`ifdef UART_PARITY_EN
        if (rx_baud == BAUD_LAST) begin
          rx_baud_n    = '0;
          rx_par_bit_n = rx_sync;
          rx_state_n   = STOP;
        end
`else
        rx_state_n = IDLE;
`endif
      end
      STOP: begin
        if (rx_baud == BAUD_LAST) begin
          rx_baud_n  = '0;
          rx_state_n = IDLE;
          if (rx_sync != UART_IDLE_LEVEL) begin
            frame_err_n = 1'b1;
          end
`ifdef UART_PARITY_EN
          else if (^{rx_shift, rx_par_bit}) begin
            parity_err_n = 1'b1;
          end
`endif
          else begin
            // The FIFO refuses the push when it is full with no pop this cycle.
            rx_push   = 1'b1;
            overrun_n = rx_full && !rx_pop;
          end
        end
      end
      default: begin
        rx_baud_n  = '0;
        rx_state_n = IDLE;
      end
    endcase
  end

  // RX registers and the one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state     <= IDLE;
      rx_baud      <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bit    <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_state     <= rx_state_n;
      rx_baud      <= rx_baud_n;
      rx_bit       <= rx_bit_n;
      rx_shift     <= rx_shift_n;
      rx_frame_err <= frame_err_n;
      rx_overrun   <= overrun_n;
`ifdef UART_PARITY_EN
      rx_par_bit    <= rx_par_bit_n;
      rx_parity_err <= parity_err_n;
`endif
    end
  end

endmodule
